// File: rtl/dot_prod_stream.sv
// rtl/dot_prod_stream.sv - sample-serial pipelined complex dot product with streaming result
//
// Accumulates sum over LENGTH beats of x*y (conj_mode=0) or x*conj(y) (conj_mode=1).
// The mode is latched on the first beat of each vector.
// Pipeline: products -> re/im combine -> accumulate/output, so the result appears
// three cycles after the last beat is accepted.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   conj_mode              conjugate select, sampled on the first beat of a vector
//   m_axis_x_tvalid/tready x sample handshake; xi/xq are signed XI_BITS
//   m_axis_y_tvalid/tready y sample handshake; yi/yq are signed YI_BITS
//   s_axis_tvalid          result valid
//   m_axis_product_tready  downstream ready
//   i, q                   signed ACC_BITS result
module dot_prod_stream #(
  parameter int XI_BITS = 12,
  parameter int YI_BITS = 12,
  parameter int LENGTH  = 16,
  localparam int P        = XI_BITS + YI_BITS,
  localparam int ACC_BITS = P + 1 + $clog2(LENGTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       conj_mode,
  input  logic                       m_axis_x_tvalid,
  output logic                       m_axis_x_tready,
  input  logic signed [XI_BITS-1:0]  xi,
  input  logic signed [XI_BITS-1:0]  xq,
  input  logic                       m_axis_y_tvalid,
  output logic                       m_axis_y_tready,
  input  logic signed [YI_BITS-1:0]  yi,
  input  logic signed [YI_BITS-1:0]  yq,
  output logic                       s_axis_tvalid,
  input  logic                       m_axis_product_tready,
  output logic signed [ACC_BITS-1:0] i,
  output logic signed [ACC_BITS-1:0] q
);

  localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);

  // Beat counter and latched mode
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;

  // Stage 1: raw products and beat flags
  logic             s1_valid_q, s1_valid_d;
  logic             s1_first_q, s1_first_d;
  logic             s1_last_q, s1_last_d;
  logic             s1_mode_q, s1_mode_d;
  logic signed [P-1:0] s1_pii_q, s1_pii_d;
  logic signed [P-1:0] s1_pqq_q, s1_pqq_d;
  logic signed [P-1:0] s1_pqi_q, s1_pqi_d;
  logic signed [P-1:0] s1_piq_q, s1_piq_d;

  // Stage 2: combined real/imaginary terms
  logic             s2_valid_q, s2_valid_d;
  logic             s2_first_q, s2_first_d;
  logic             s2_last_q, s2_last_d;
  logic signed [P:0] s2_re_q, s2_re_d;
  logic signed [P:0] s2_im_q, s2_im_d;

  // Stage 3: accumulator and output register
  logic signed [ACC_BITS-1:0] acc_re_q, acc_re_d;
  logic signed [ACC_BITS-1:0] acc_im_q, acc_im_d;
  logic signed [ACC_BITS-1:0] i_q, i_d;
  logic signed [ACC_BITS-1:0] q_q, q_d;
  logic                       out_valid_q, out_valid_d;

  logic en;
  logic beat;
  logic first_beat;
  logic last_beat;
  logic beat_mode;
  logic signed [ACC_BITS-1:0] sum_re;
  logic signed [ACC_BITS-1:0] sum_im;

  // A held, unaccepted result freezes every stage so nothing is lost.
  assign en              = !(out_valid_q && !m_axis_product_tready);
  assign m_axis_x_tready = en && !reset;
  assign m_axis_y_tready = en && !reset;
  assign beat            = m_axis_x_tvalid && m_axis_y_tvalid && en && !reset;

  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == LAST_CNT);
  // First beat uses the live mode; later beats reuse the one latched on beat 0.
  assign beat_mode  = first_beat ? conj_mode : mode_q;

  // First beat of a vector restarts the sum instead of adding to stale acc.
  assign sum_re = s2_first_q ? ACC_BITS'(s2_re_q) : acc_re_q + ACC_BITS'(s2_re_q);
  assign sum_im = s2_first_q ? ACC_BITS'(s2_im_q) : acc_im_q + ACC_BITS'(s2_im_q);

  always_comb begin
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_mode_d   = s1_mode_q;
    s1_pii_d    = s1_pii_q;
    s1_pqq_d    = s1_pqq_q;
    s1_pqi_d    = s1_pqi_q;
    s1_piq_d    = s1_piq_q;
    s2_valid_d  = s2_valid_q;
    s2_first_d  = s2_first_q;
    s2_last_d   = s2_last_q;
    s2_re_d     = s2_re_q;
    s2_im_d     = s2_im_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    i_d         = i_q;
    q_d         = q_q;
    out_valid_d = out_valid_q;

    if (beat) begin
      cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
      if (first_beat) begin
        mode_d = conj_mode;
      end
    end

    // Consumed result drops valid; a load below in the same cycle overrides this.
    if (out_valid_q && m_axis_product_tready) begin
      out_valid_d = 1'b0;
    end

    if (en) begin
      s1_valid_d = beat;
      s1_first_d = first_beat;
      s1_last_d  = last_beat;
      s1_mode_d  = beat_mode;
      s1_pii_d   = P'(xi) * P'(yi);
      s1_pqq_d   = P'(xq) * P'(yq);
      s1_pqi_d   = P'(xq) * P'(yi);
      s1_piq_d   = P'(xi) * P'(yq);

      s2_valid_d = s1_valid_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      if (s1_mode_q) begin
        s2_re_d = (P + 1)'(s1_pii_q) + (P + 1)'(s1_pqq_q);
        s2_im_d = (P + 1)'(s1_pqi_q) - (P + 1)'(s1_piq_q);
      end else begin
        s2_re_d = (P + 1)'(s1_pii_q) - (P + 1)'(s1_pqq_q);
        s2_im_d = (P + 1)'(s1_pqi_q) + (P + 1)'(s1_piq_q);
      end

      if (s2_valid_q) begin
        acc_re_d = sum_re;
        acc_im_d = sum_im;
        if (s2_last_q) begin
          i_d         = sum_re;
          q_d         = sum_im;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_pii_q    <= '0;
      s1_pqq_q    <= '0;
      s1_pqi_q    <= '0;
      s1_piq_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_re_q     <= '0;
      s2_im_q     <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      i_q         <= '0;
      q_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_mode_q   <= s1_mode_d;
      s1_pii_q    <= s1_pii_d;
      s1_pqq_q    <= s1_pqq_d;
      s1_pqi_q    <= s1_pqi_d;
      s1_piq_q    <= s1_piq_d;
      s2_valid_q  <= s2_valid_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_re_q     <= s2_re_d;
      s2_im_q     <= s2_im_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      i_q         <= i_d;
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s_axis_tvalid = out_valid_q;
  assign i             = i_q;
  assign q             = q_q;

endmodule

// File: tb/tb_dot_prod_stream.sv
// tb/tb_dot_prod_stream.sv - directed vector bench for dot_prod_stream (LENGTH=4 and LENGTH=1)
module tb_dot_prod_stream;

  logic clk = 1'b0;
  logic reset;
  logic conj_mode;
  logic vx, vy;
  logic signed [11:0] xi, xq, yi, yq;
  logic rdy4, rdy1;

  logic xr4, yr4, tv4;
  logic signed [26:0] i4, q4;
  logic xr1, yr1, tv1;
  logic signed [24:0] i1, q1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dot_prod_stream #(.XI_BITS(12), .YI_BITS(12), .LENGTH(4)) dut4 (
    .clk(clk), .reset(reset), .conj_mode(conj_mode),
    .m_axis_x_tvalid(vx), .m_axis_x_tready(xr4), .xi(xi), .xq(xq),
    .m_axis_y_tvalid(vy), .m_axis_y_tready(yr4), .yi(yi), .yq(yq),
    .s_axis_tvalid(tv4), .m_axis_product_tready(rdy4), .i(i4), .q(q4)
  );

  dot_prod_stream #(.XI_BITS(12), .YI_BITS(12), .LENGTH(1)) dut1 (
    .clk(clk), .reset(reset), .conj_mode(conj_mode),
    .m_axis_x_tvalid(vx), .m_axis_x_tready(xr1), .xi(xi), .xq(xq),
    .m_axis_y_tvalid(vy), .m_axis_y_tready(yr1), .yi(yi), .yq(yq),
    .s_axis_tvalid(tv1), .m_axis_product_tready(rdy1), .i(i1), .q(q1)
  );

  typedef struct {
    logic signed [11:0] xi, xq, yi, yq;
    logic               conj;
    logic               tog;
    longint             ei, eq;
  } vec_t;

  vec_t tbl[9];
  vec_t t1[6];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_data(input vec_t v);
    xi = v.xi; xq = v.xq; yi = v.yi; yq = v.yq;
  endtask

  // Four gap-free beats on dut4, then latency and value checks.
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    set_data(v);
    for (int b = 0; b < 4; b++) begin
      conj_mode = (b == 0) ? v.conj : (v.tog ? ~v.conj : v.conj);
      vx = 1'b1; vy = 1'b1;
      @(posedge clk); #1;
    end
    vx = 1'b0; vy = 1'b0;
    lat = 1;
    while (!tv4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, lat, 3);
    check({name, "_i"}, i4, v.ei);
    check({name, "_q"}, q4, v.eq);
    @(posedge clk); #1;
    check({name, "_clr"}, tv4, 0);
  endtask

  // Holds one beat until dut4 accepts it (tready sampled mid-cycle).
  task automatic send_beat(input vec_t v);
    logic acc;
    int k;
    set_data(v);
    conj_mode = v.conj;
    vx = 1'b1; vy = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      acc = xr4;
      @(posedge clk); #1;
      k++;
    end while (!acc && k < 100);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  initial begin
    longint ri[2], rq[2];
    int got, n, beats, extra;

    tbl[0] = '{12'sd1, 12'sd1, 12'sd1, 12'sd1, 1'b0, 1'b0, 0, 8};
    tbl[1] = '{12'sd1, 12'sd1, 12'sd1, 12'sd1, 1'b1, 1'b0, 8, 0};
    tbl[2] = '{12'sd1, 12'sd1, 12'sd1, 12'sd1, 1'b0, 1'b1, 0, 8};
    tbl[3] = '{12'sd1, 12'sd1, 12'sd1, 12'sd1, 1'b1, 1'b1, 8, 0};
    tbl[4] = '{-12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048, 1'b0, 1'b0, 0, 33554432};
    tbl[5] = '{-12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048, 1'b1, 1'b0, 33554432, 0};
    tbl[6] = '{12'sd3, 12'sd2, 12'sd1, -12'sd4, 1'b0, 1'b0, 44, -40};
    tbl[7] = '{12'sd3, 12'sd2, 12'sd1, -12'sd4, 1'b1, 1'b1, -20, 56};
    tbl[8] = '{12'sd2047, -12'sd2048, -12'sd2048, 12'sd2047, 1'b0, 1'b0, 0, 33538052};

    t1[0] = '{12'sd1, 12'sd1, 12'sd1, 12'sd1, 1'b0, 1'b0, 0, 2};
    t1[1] = '{12'sd1, 12'sd1, 12'sd1, 12'sd1, 1'b1, 1'b0, 2, 0};
    t1[2] = '{12'sd3, 12'sd2, 12'sd1, -12'sd4, 1'b0, 1'b0, 11, -10};
    t1[3] = '{12'sd3, 12'sd2, 12'sd1, -12'sd4, 1'b1, 1'b0, -5, 14};
    t1[4] = '{-12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048, 1'b0, 1'b0, 0, 8388608};
    t1[5] = '{12'sd2047, -12'sd2048, -12'sd2048, 12'sd2047, 1'b0, 1'b0, 0, 8384513};

    // Reset held with valids high
    reset = 1'b1; conj_mode = 1'b0; vx = 1'b1; vy = 1'b1;
    xi = 12'sd1; xq = 12'sd1; yi = 12'sd1; yq = 12'sd1;
    rdy4 = 1'b1; rdy1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", tv4, 0);
    check("rst_i", i4, 0);
    check("rst_q", q4, 0);
    check("rst_xready", xr4, 0);
    check("rst_yready", yr4, 0);
    reset = 1'b0; vx = 1'b0; vy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_ready", xr4, 1);

    // Directed table
    for (int k = 0; k < 9; k++) begin
      run_vec(tbl[k], $sformatf("vec%0d", k));
    end

    // Backpressure across two back-to-back vectors
    rdy4 = 1'b0;
    fork
      begin
        for (int b = 0; b < 8; b++) send_beat((b < 4) ? tbl[0] : tbl[6]);
        vx = 1'b0; vy = 1'b0;
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!tv4 && n < 60);
        check("bp_valid", tv4, 1);
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("bp_hold_valid", tv4, 1);
          check("bp_hold_ready", xr4, 0);
          check("bp_hold_i", i4, 0);
          check("bp_hold_q", q4, 8);
        end
        @(posedge clk); #1;
        rdy4 = 1'b1;
        got = 0; n = 0;
        while (got < 2 && n < 60) begin
          @(negedge clk);
          n++;
          if (tv4 && rdy4) begin
            ri[got] = i4; rq[got] = q4;
            got++;
          end
        end
        check("bp_count", got, 2);
        check("bp_r0_i", ri[0], 0);
        check("bp_r0_q", rq[0], 8);
        check("bp_r1_i", ri[1], 44);
        check("bp_r1_q", rq[1], -40);
      end
    join
    @(posedge clk); #1;

    // Lone x valid, then random joint gaps
    set_data(tbl[6]);
    conj_mode = 1'b0;
    vx = 1'b1; vy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    beats = 0; n = 0;
    while (beats < 4 && n < 200) begin
      vx = 1'($urandom_range(0, 1));
      vy = 1'($urandom_range(0, 1));
      conj_mode = (beats == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (vx && vy && xr4) beats++;
      @(posedge clk); #1;
      n++;
    end
    vx = 1'b0; vy = 1'b0;
    check("gap_beats", beats, 4);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tv4 && n < 20);
    check("gap_valid", tv4, 1);
    check("gap_i", i4, 44);
    check("gap_q", q4, -40);
    @(posedge clk); #1;

    // Reset after two beats discards the partial vector
    set_data(tbl[6]);
    conj_mode = 1'b0;
    vx = 1'b1; vy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vx = 1'b0; vy = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    run_vec(tbl[0], "midrst");
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (tv4) extra++;
    end
    check("midrst_extra", extra, 0);

    // LENGTH=1: one result per beat, three-cycle latency
    for (int s = 0; s < 10; s++) begin
      @(posedge clk); #1;
      if (s >= 3 && s < 9) begin
        check($sformatf("len1_valid%0d", s - 3), tv1, 1);
        check($sformatf("len1_i%0d", s - 3), i1, t1[s - 3].ei);
        check($sformatf("len1_q%0d", s - 3), q1, t1[s - 3].eq);
      end else begin
        check($sformatf("len1_idle%0d", s), tv1, 0);
      end
      if (s < 6) begin
        set_data(t1[s]);
        conj_mode = t1[s].conj;
        vx = 1'b1; vy = 1'b1;
      end else begin
        vx = 1'b0; vy = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
